// File: rtl/aemb_wb_bus_arbiter.sv
// Two-master Wishbone arbiter: dwb (master 0) and iwb (master 1) share one slave port.
// Optional stall watchdog enabled by defining AEMB_ARB_WATCHDOG_EN.
module aemb_wb_bus_arbiter #(
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32,
  parameter int unsigned TAGW     = 3,
  parameter int unsigned PRIORITY = 1,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              reset,

  input  logic [AW-1:0]     dwb_adr_i,
  input  logic [DW-1:0]     dwb_dat_i,
  input  logic [DW/8-1:0]   dwb_sel_i,
  input  logic [TAGW-1:0]   dwb_tag_i,
  input  logic              dwb_cyc_i,
  input  logic              dwb_stb_i,
  input  logic              dwb_wre_i,
  output logic [DW-1:0]     dwb_dat_o,
  output logic              dwb_ack_o,
  output logic              dwb_err_o,
  output logic              dwb_rty_o,

  input  logic [AW-1:0]     iwb_adr_i,
  input  logic [DW-1:0]     iwb_dat_i,
  input  logic [DW/8-1:0]   iwb_sel_i,
  input  logic [TAGW-1:0]   iwb_tag_i,
  input  logic              iwb_cyc_i,
  input  logic              iwb_stb_i,
  input  logic              iwb_wre_i,
  output logic [DW-1:0]     iwb_dat_o,
  output logic              iwb_ack_o,
  output logic              iwb_err_o,
  output logic              iwb_rty_o,

  output logic [AW-1:0]     s_adr_o,
  output logic [DW-1:0]     s_dat_o,
  output logic [DW/8-1:0]   s_sel_o,
  output logic [TAGW-1:0]   s_tag_o,
  output logic              s_cyc_o,
  output logic              s_stb_o,
  output logic              s_wre_o,
  input  logic [DW-1:0]     s_dat_i,
  input  logic              s_ack_i,
  input  logic              s_err_i,
  input  logic              s_rty_i,

  output logic [1:0]        gnt_o
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StGntD = 2'd1;
  localparam logic [1:0] StGntI = 2'd2;

  logic [1:0] state_q, state_d;
  logic       last_q, last_d;  // master served most recently: 0 dwb, 1 iwb
  logic [1:0] gnt_q, gnt_d;

  logic grant_d, grant_i, granted;
  logic pick_i;
  logic sel_stb;
  logic wd_hit;

  assign grant_d = (state_q == StGntD);
  assign grant_i = (state_q == StGntI);
  assign granted = grant_d | grant_i;
  assign sel_stb = (grant_d & dwb_stb_i) | (grant_i & iwb_stb_i);

  // Round-robin hands a tie to whichever master was not served last.
  assign pick_i = iwb_cyc_i & (~dwb_cyc_i | ((PRIORITY != 0) & ~last_q));

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      StIdle: begin
        if (dwb_cyc_i || iwb_cyc_i) begin
          state_d = pick_i ? StGntI : StGntD;
          last_d  = pick_i;
        end
      end
      StGntD: if (!dwb_cyc_i || wd_hit) state_d = StIdle;
      StGntI: if (!iwb_cyc_i || wd_hit) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign gnt_d = {state_d == StGntI, state_d == StGntD};
  assign gnt_o = gnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      last_q  <= 1'b1;
      gnt_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
    end
  end

`ifdef AEMB_ARB_WATCHDOG_EN
  logic [15:0] wd_cnt_q, wd_cnt_d;
  logic        any_resp;

  assign any_resp = s_ack_i | s_err_i | s_rty_i;
  // Fires in the TIMEOUT-th consecutive stalled strobe cycle.
  assign wd_hit   = granted & sel_stb & ~any_resp & (wd_cnt_q == 16'(TIMEOUT - 1));

  always_comb begin
    wd_cnt_d = wd_cnt_q;
    if (!granted || any_resp || wd_hit) begin
      wd_cnt_d = 16'd0;
    end else if (sel_stb) begin
      wd_cnt_d = wd_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_cnt_q <= 16'd0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^32'(TIMEOUT);
  assign wd_hit = 1'b0;
`endif

  always_comb begin
    s_adr_o   = '0;
    s_dat_o   = '0;
    s_sel_o   = '0;
    s_tag_o   = '0;
    s_cyc_o   = 1'b0;
    s_stb_o   = 1'b0;
    s_wre_o   = 1'b0;
    dwb_dat_o = '0;
    dwb_ack_o = 1'b0;
    dwb_err_o = 1'b0;
    dwb_rty_o = 1'b0;
    iwb_dat_o = '0;
    iwb_ack_o = 1'b0;
    iwb_err_o = 1'b0;
    iwb_rty_o = 1'b0;
    if (grant_d) begin
      s_adr_o   = dwb_adr_i;
      s_dat_o   = dwb_dat_i;
      s_sel_o   = dwb_sel_i;
      s_tag_o   = dwb_tag_i;
      s_cyc_o   = dwb_cyc_i & ~wd_hit;
      s_stb_o   = dwb_stb_i & ~wd_hit;
      s_wre_o   = dwb_wre_i;
      dwb_dat_o = s_dat_i;
      dwb_ack_o = s_ack_i;
      dwb_err_o = s_err_i | wd_hit;
      dwb_rty_o = s_rty_i;
    end else if (grant_i) begin
      s_adr_o   = iwb_adr_i;
      s_dat_o   = iwb_dat_i;
      s_sel_o   = iwb_sel_i;
      s_tag_o   = iwb_tag_i;
      s_cyc_o   = iwb_cyc_i & ~wd_hit;
      s_stb_o   = iwb_stb_i & ~wd_hit;
      s_wre_o   = iwb_wre_i;
      iwb_dat_o = s_dat_i;
      iwb_ack_o = s_ack_i;
      iwb_err_o = s_err_i | wd_hit;
      iwb_rty_o = s_rty_i;
    end
  end

endmodule

// File: tb/tb_aemb_wb_bus_arbiter.sv
// Bench for aemb_wb_bus_arbiter: round-robin and fixed-priority instances share one stimulus.
// Watchdog checks run when AEMB_ARB_WATCHDOG_EN is defined.
module tb_aemb_wb_bus_arbiter;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TAGW = 3;
  localparam int unsigned TMO = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [AW-1:0] d_adr, i_adr;
  logic [DW-1:0] d_dat, i_dat, s_dat;
  logic [3:0]    d_sel, i_sel;
  logic [TAGW-1:0] d_tag, i_tag;
  logic d_cyc, d_stb, d_wre, i_cyc, i_stb, i_wre, s_ack, s_err, s_rty;

  logic [DW-1:0] r_ddat, r_idat, r_sdat, f_ddat, f_idat, f_sdat;
  logic r_dack, r_derr, r_drty, r_iack, r_ierr, r_irty;
  logic f_dack, f_derr, f_drty, f_iack, f_ierr, f_irty;
  logic [AW-1:0] r_sadr, f_sadr;
  logic [3:0] r_ssel, f_ssel;
  logic [TAGW-1:0] r_stag, f_stag;
  logic r_scyc, r_sstb, r_swre, f_scyc, f_sstb, f_swre;
  logic [1:0] r_gnt, f_gnt;

  aemb_wb_bus_arbiter #(.AW(AW), .DW(DW), .TAGW(TAGW), .PRIORITY(1), .TIMEOUT(TMO)) u_rr (
    .clk(clk), .reset(reset),
    .dwb_adr_i(d_adr), .dwb_dat_i(d_dat), .dwb_sel_i(d_sel), .dwb_tag_i(d_tag),
    .dwb_cyc_i(d_cyc), .dwb_stb_i(d_stb), .dwb_wre_i(d_wre),
    .dwb_dat_o(r_ddat), .dwb_ack_o(r_dack), .dwb_err_o(r_derr), .dwb_rty_o(r_drty),
    .iwb_adr_i(i_adr), .iwb_dat_i(i_dat), .iwb_sel_i(i_sel), .iwb_tag_i(i_tag),
    .iwb_cyc_i(i_cyc), .iwb_stb_i(i_stb), .iwb_wre_i(i_wre),
    .iwb_dat_o(r_idat), .iwb_ack_o(r_iack), .iwb_err_o(r_ierr), .iwb_rty_o(r_irty),
    .s_adr_o(r_sadr), .s_dat_o(r_sdat), .s_sel_o(r_ssel), .s_tag_o(r_stag),
    .s_cyc_o(r_scyc), .s_stb_o(r_sstb), .s_wre_o(r_swre),
    .s_dat_i(s_dat), .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty),
    .gnt_o(r_gnt)
  );

  aemb_wb_bus_arbiter #(.AW(AW), .DW(DW), .TAGW(TAGW), .PRIORITY(0), .TIMEOUT(TMO)) u_fx (
    .clk(clk), .reset(reset),
    .dwb_adr_i(d_adr), .dwb_dat_i(d_dat), .dwb_sel_i(d_sel), .dwb_tag_i(d_tag),
    .dwb_cyc_i(d_cyc), .dwb_stb_i(d_stb), .dwb_wre_i(d_wre),
    .dwb_dat_o(f_ddat), .dwb_ack_o(f_dack), .dwb_err_o(f_derr), .dwb_rty_o(f_drty),
    .iwb_adr_i(i_adr), .iwb_dat_i(i_dat), .iwb_sel_i(i_sel), .iwb_tag_i(i_tag),
    .iwb_cyc_i(i_cyc), .iwb_stb_i(i_stb), .iwb_wre_i(i_wre),
    .iwb_dat_o(f_idat), .iwb_ack_o(f_iack), .iwb_err_o(f_ierr), .iwb_rty_o(f_irty),
    .s_adr_o(f_sadr), .s_dat_o(f_sdat), .s_sel_o(f_ssel), .s_tag_o(f_stag),
    .s_cyc_o(f_scyc), .s_stb_o(f_sstb), .s_wre_o(f_swre),
    .s_dat_i(s_dat), .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty),
    .gnt_o(f_gnt)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: owner -1 = nobody (turnaround/idle), 0 = dwb, 1 = iwb.
  int own_r, last_r, wd_r, own_f, last_f, wd_f;

  function automatic logic cyc_of(int own);
    return (own == 0) ? d_cyc : (own == 1) ? i_cyc : 1'b0;
  endfunction

  function automatic logic stb_of(int own);
    return (own == 0) ? d_stb : (own == 1) ? i_stb : 1'b0;
  endfunction

  function automatic logic hit(int own, int wd);
`ifdef AEMB_ARB_WATCHDOG_EN
    return (own >= 0) && stb_of(own) && !(s_ack || s_err || s_rty) && (wd + 1 == TMO);
`else
    return (own < -1) && (wd < 0);
`endif
  endfunction

  function automatic int pick(int prio, int last);
    if (d_cyc && i_cyc) return (prio == 0) ? 0 : ((last == 0) ? 1 : 0);
    return d_cyc ? 0 : 1;
  endfunction

  task automatic adv(inout int own, inout int last, inout int wd, input int prio);
    logic h;
    h = hit(own, wd);
    if (own < 0 || s_ack || s_err || s_rty || h) wd = 0;
    else if (stb_of(own)) wd++;
    if (own < 0) begin
      if (d_cyc || i_cyc) begin
        own  = pick(prio, last);
        last = own;
      end
    end else if (h || !cyc_of(own)) begin
      own = -1;
    end
  endtask

  task automatic check_model();
    logic h, hf;
    h  = hit(own_r, wd_r);
    hf = hit(own_f, wd_f);
    chk("rr_gnt", r_gnt, (own_r < 0) ? 2'b00 : (own_r == 0) ? 2'b01 : 2'b10);
    chk("rr_s_cyc", r_scyc, cyc_of(own_r) && !h);
    chk("rr_s_stb", r_sstb, stb_of(own_r) && !h);
    chk("rr_s_adr", r_sadr, (own_r == 0) ? d_adr : (own_r == 1) ? i_adr : '0);
    chk("rr_s_dat", r_sdat, (own_r == 0) ? d_dat : (own_r == 1) ? i_dat : '0);
    chk("rr_s_wre", r_swre, (own_r == 0) ? d_wre : (own_r == 1) ? i_wre : 1'b0);
    chk("rr_s_tag", r_stag, (own_r == 0) ? d_tag : (own_r == 1) ? i_tag : '0);
    chk("rr_dwb_ack", r_dack, (own_r == 0) && s_ack);
    chk("rr_dwb_err", r_derr, (own_r == 0) && (s_err || h));
    chk("rr_dwb_dat", r_ddat, (own_r == 0) ? s_dat : '0);
    chk("rr_iwb_ack", r_iack, (own_r == 1) && s_ack);
    chk("rr_iwb_rty", r_irty, (own_r == 1) && s_rty);
    chk("rr_iwb_dat", r_idat, (own_r == 1) ? s_dat : '0);
    chk("fx_gnt", f_gnt, (own_f < 0) ? 2'b00 : (own_f == 0) ? 2'b01 : 2'b10);
    chk("fx_s_cyc", f_scyc, cyc_of(own_f) && !hf);
  endtask

  task automatic clear_inputs();
    {d_adr, d_dat, d_sel, d_tag, d_cyc, d_stb, d_wre} = '0;
    {i_adr, i_dat, i_sel, i_tag, i_cyc, i_stb, i_wre} = '0;
    {s_dat, s_ack, s_err, s_rty} = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    own_r = -1; last_r = 1; wd_r = 0;
    own_f = -1; last_f = 1; wd_f = 0;
  endtask

  typedef struct {
    logic rst, dc, ic, ack;
    logic [1:0] g_r, g_f;
    logic sc_r, da_r, ia_r;
  } vec_t;

  vec_t tbl[13];
  int   rr_seq[$];

  initial begin : watchdog_timer
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic dseen, iseen;
    logic [1:0] prev;
    int exp_seq[5];
    int k;
    reset = 1'b1;
    clear_inputs();
    #2 reset = 1'b0;

    // rst dc ic ack | gnt_rr gnt_fx s_cyc_rr dack_rr iack_rr
    tbl[0]  = '{1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 2'b01, 2'b01, 1'b1, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 2'b10, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 2'b10, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 2'b10, 2'b01, 1'b1, 1'b0, 1'b1};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};

    for (int v = 0; v < 13; v++) begin
      @(negedge clk);
      reset = tbl[v].rst;
      d_cyc = tbl[v].dc; d_stb = tbl[v].dc;
      i_cyc = tbl[v].ic; i_stb = tbl[v].ic;
      s_ack = tbl[v].ack;
      #1;
      chk($sformatf("tbl%0d_gnt_rr", v), r_gnt, tbl[v].g_r);
      chk($sformatf("tbl%0d_gnt_fx", v), f_gnt, tbl[v].g_f);
      chk($sformatf("tbl%0d_scyc_rr", v), r_scyc, tbl[v].sc_r);
      chk($sformatf("tbl%0d_dack_rr", v), r_dack, tbl[v].da_r);
      chk($sformatf("tbl%0d_iack_rr", v), r_iack, tbl[v].ia_r);
    end

    // Round-robin with both masters re-requesting after each single-beat ack.
    do_reset();
    dseen = 1'b0; iseen = 1'b0; prev = 2'b00;
    for (int c = 0; c < 40 && rr_seq.size() < 5; c++) begin
      @(negedge clk);
      d_cyc = !dseen; d_stb = d_cyc;
      i_cyc = !iseen; i_stb = i_cyc;
      s_ack = 1'b0;
      #1 s_ack = r_sstb;
      #1;
      dseen = r_dack; iseen = r_iack;
      if (rr_seq.size() == 0) begin
        if (r_gnt != 2'b00) rr_seq.push_back(int'(r_gnt));
      end else if (r_gnt != prev) begin
        rr_seq.push_back(int'(r_gnt));
      end
      prev = r_gnt;
    end
    exp_seq = '{1, 0, 2, 0, 1};
    chk("rr_seq_len", rr_seq.size(), 5);
    for (int j = 0; j < 5; j++) begin
      k = (j < rr_seq.size()) ? rr_seq[j] : -1;
      chk($sformatf("rr_seq%0d", j), k, exp_seq[j]);
    end

    // iwb read with data return.
    do_reset();
    i_cyc = 1'b1; i_stb = 1'b1; i_adr = 32'h100; i_sel = 4'hf;
    for (int c = 0; c < 5 && r_gnt != 2'b10; c++) begin
      @(negedge clk);
      #1 chk("rd_dack_wait", r_dack, 1'b0);
    end
    chk("rd_gnt", r_gnt, 2'b10);
    s_dat = 32'hDEADBEEF; s_ack = 1'b1;
    #1;
    chk("rd_iwb_dat", r_idat, 32'hDEADBEEF);
    chk("rd_iwb_ack", r_iack, 1'b1);
    chk("rd_s_adr", r_sadr, 32'h100);
    chk("rd_dwb_ack", r_dack, 1'b0);
    chk("rd_dwb_dat", r_ddat, 32'h0);

`ifdef AEMB_ARB_WATCHDOG_EN
    // Stalled dwb write is terminated in its TMO-th strobe cycle.
    do_reset();
    d_cyc = 1'b1; d_stb = 1'b1; d_wre = 1'b1;
    for (int c = 0; c < 5 && r_gnt != 2'b01; c++) begin
      @(negedge clk);
      #1;
    end
    for (int s = 1; s <= int'(TMO); s++) begin
      if (s > 1) begin
        @(negedge clk);
        #1;
      end
      chk($sformatf("wd%0d_err", s), r_derr, s == int'(TMO));
      chk($sformatf("wd%0d_scyc", s), r_scyc, s != int'(TMO));
    end
    @(negedge clk);
    #1 chk("wd_gnt_after", r_gnt, 2'b00);
`endif

    // Asynchronous reset in the middle of an iwb transfer.
    do_reset();
    i_cyc = 1'b1; i_stb = 1'b1;
    for (int c = 0; c < 5 && r_gnt != 2'b10; c++) begin
      @(negedge clk);
      #1;
    end
    chk("mr_gnt_before", r_gnt, 2'b10);
    #1 reset = 1'b0;
    #1;
    chk("mr_scyc", r_scyc, 1'b0);
    chk("mr_gnt", r_gnt, 2'b00);
    @(negedge clk);
    reset = 1'b1; i_cyc = 1'b0; i_stb = 1'b0; s_ack = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1 chk($sformatf("mr_iack%0d", c), r_iack, 1'b0);
      @(negedge clk);
    end

    // Random traffic against the reference model.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      d_cyc = ($urandom % 4) != 0; d_stb = d_cyc & (($urandom % 4) != 0);
      i_cyc = ($urandom % 4) != 0; i_stb = i_cyc & (($urandom % 4) != 0);
      d_adr = $urandom; d_dat = $urandom; d_sel = 4'($urandom); d_tag = 3'($urandom);
      i_adr = $urandom; i_dat = $urandom; i_sel = 4'($urandom); i_tag = 3'($urandom);
      d_wre = 1'($urandom); i_wre = 1'($urandom);
      s_dat = $urandom;
      s_ack = ($urandom % 3) == 0;
      s_err = ($urandom % 10) == 0;
      s_rty = ($urandom % 10) == 0;
      #1 check_model();
      @(posedge clk);
      adv(own_r, last_r, wd_r, 1);
      adv(own_f, last_f, wd_f, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
